// File: rtl/hazard_ctrl_pkg.sv
// hazard_ctrl_pkg: FSM encoding, operand-forward selects and
// the pipeline control bundle shared by the hazard unit.
package hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LD_STALL = 2'd1,
    MC_WAIT  = 2'd2
  } hcState_t;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  typedef struct packed {
    logic stallIf;
    logic stallDec;
    logic stallEx;
    logic killDec;
    logic flushIf;
    logic flushDec;
    logic mcErr;
  } hcCtl_t;

endpackage

// File: rtl/hazard_fwd_sel.sv
// hazard_fwd_sel: picks the EX operand source for one source
// register; the younger MEM result wins over WB.
module hazard_fwd_sel
  import hazard_ctrl_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] exRs,
  input  logic [REG_AW-1:0] memRd,
  input  logic              memRegWrite,
  input  logic [REG_AW-1:0] wbRd,
  input  logic              wbRegWrite,
  output logic [1:0]        fwdSel
);

  logic memHit;
  logic wbHit;

  assign memHit = memRegWrite
               && (memRd != '0)
               && (memRd == exRs);

  // masked by memHit so the decode below is one-hot
  assign wbHit = wbRegWrite
              && (wbRd != '0)
              && (wbRd == exRs)
              && !memHit;

  always_comb begin
    fwdSel = FWD_RF;
    unique case (1'b1)
      memHit:  fwdSel = FWD_MEM;
      wbHit:   fwdSel = FWD_WB;
      default: fwdSel = FWD_RF;
    endcase
  end

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: load-use and multicycle stall FSM, branch flush
// and EX operand forwarding for the in-order pipeline.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int REG_AW     = 5,
  parameter int LOAD_STALL = 1,
  parameter int MC_TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic [REG_AW-1:0] ex_rs1,
  input  logic [REG_AW-1:0] ex_rs2,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_reg_write,
  input  logic              ex_mem_read,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic              mem_reg_write,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic              wb_reg_write,
  input  logic              mc_start,
  input  logic              mc_done,
  input  logic              branch_taken,
  output logic              stall_IF,
  output logic              stall_DEC,
  output logic              stall_EX,
  output logic              kill_DEC,
  output logic              flush_IF,
  output logic              flush_DEC,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic              busy,
  output logic              mc_err
);

  localparam int CW = $clog2(MC_TIMEOUT + 1);

  localparam logic [CW-1:0] One    = CW'(1);
  localparam logic [CW-1:0] LdInit = CW'(LOAD_STALL - 1);
  localparam logic [CW-1:0] McLast = CW'(MC_TIMEOUT - 1);

  hcState_t      state;
  hcState_t      stateNxt;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cntNxt;
  hcCtl_t        ctl;
  hcCtl_t        ctlOut;
  logic          rs1Hit;
  logic          rs2Hit;
  logic          loadUse;
  logic [1:0]    selA;
  logic [1:0]    selB;

  assign rs1Hit = id_use_rs1 && (id_rs1 == ex_rd);
  assign rs2Hit = id_use_rs2 && (id_rs2 == ex_rd);

  assign loadUse = ex_mem_read
                && ex_reg_write
                && (ex_rd != '0)
                && (rs1Hit || rs2Hit);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= stateNxt;
      cnt   <= cntNxt;
    end
  end

  always_comb begin
    stateNxt = state;
    cntNxt   = cnt;
    ctl      = '0;
    unique case (state)
      RUN: begin
        if (branch_taken) begin
          ctl.flushIf  = 1'b1;
          ctl.flushDec = 1'b1;
        end else if (mc_start) begin
          stateNxt = MC_WAIT;
          cntNxt   = '0;
        end else if (loadUse) begin
          ctl.stallIf  = 1'b1;
          ctl.stallDec = 1'b1;
          ctl.killDec  = 1'b1;
          if (LOAD_STALL > 1) begin
            stateNxt = LD_STALL;
            cntNxt   = LdInit;
          end
        end
      end
      LD_STALL: begin
        if (branch_taken) begin
          ctl.flushIf  = 1'b1;
          ctl.flushDec = 1'b1;
          stateNxt     = RUN;
          cntNxt       = '0;
        end else begin
          ctl.stallIf  = 1'b1;
          ctl.stallDec = 1'b1;
          ctl.killDec  = 1'b1;
          cntNxt       = cnt - One;
          if (cnt == One) stateNxt = RUN;
        end
      end
      MC_WAIT: begin
        if (mc_done) begin
          stateNxt = RUN;
          cntNxt   = '0;
        end else if (cnt == McLast) begin
          ctl.mcErr = 1'b1;
          stateNxt  = RUN;
          cntNxt    = '0;
        end else begin
          ctl.stallIf  = 1'b1;
          ctl.stallDec = 1'b1;
          ctl.stallEx  = 1'b1;
          cntNxt       = cnt + One;
        end
      end
      default: begin
        stateNxt = RUN;
        cntNxt   = '0;
      end
    endcase
  end

  // reset quiets every output, even before the first clock edge
  assign ctlOut = rst ? hcCtl_t'('0) : ctl;

  assign stall_IF  = ctlOut.stallIf;
  assign stall_DEC = ctlOut.stallDec;
  assign stall_EX  = ctlOut.stallEx;
  assign kill_DEC  = ctlOut.killDec;
  assign flush_IF  = ctlOut.flushIf;
  assign flush_DEC = ctlOut.flushDec;
  assign mc_err    = ctlOut.mcErr;
  assign busy      = !rst && (state != RUN);

  hazard_fwd_sel #(.REG_AW(REG_AW)) uFwdA (
    .exRs        (ex_rs1),
    .memRd       (mem_rd),
    .memRegWrite (mem_reg_write),
    .wbRd        (wb_rd),
    .wbRegWrite  (wb_reg_write),
    .fwdSel      (selA)
  );

  hazard_fwd_sel #(.REG_AW(REG_AW)) uFwdB (
    .exRs        (ex_rs2),
    .memRd       (mem_rd),
    .memRegWrite (mem_reg_write),
    .wbRd        (wb_rd),
    .wbRegWrite  (wb_reg_write),
    .fwdSel      (selB)
  );

  assign fwd_a = rst ? FWD_RF : selA;
  assign fwd_b = rst ? FWD_RF : selB;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed scenarios plus randomized traffic on two
// hazard_ctrl instances (LOAD_STALL 1/3) against a bubble-count model.
module tb_hazard_ctrl;

  // {stall_IF,stall_DEC,stall_EX,kill_DEC,flush_IF,flush_DEC,
  //  mc_err,busy,fwd_a,fwd_b}
  localparam logic [11:0] S_LU  = 12'b1101_0000_0000;
  localparam logic [11:0] S_MC  = 12'b1110_0000_0000;
  localparam logic [11:0] FLUSH = 12'b0000_1100_0000;
  localparam logic [11:0] ERR   = 12'b0000_0010_0000;
  localparam logic [11:0] BUSY  = 12'b0000_0001_0000;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] id_rs1, id_rs2, ex_rs1, ex_rs2;
  logic [4:0] ex_rd, mem_rd, wb_rd;
  logic       id_use_rs1, id_use_rs2;
  logic       ex_reg_write, ex_mem_read;
  logic       mem_reg_write, wb_reg_write;
  logic       mc_start, mc_done, branch_taken;

  logic [11:0] obsA;
  logic [11:0] obsB;

  int checks = 0;
  int errors = 0;

  int bubA = 0;
  int bubB = 0;
  int ageA = 0;
  int ageB = 0;
  bit mcA  = 1'b0;
  bit mcB  = 1'b0;

  hazard_ctrl #(.REG_AW(5), .LOAD_STALL(1), .MC_TIMEOUT(8)) dutA (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .mem_rd(mem_rd), .mem_reg_write(mem_reg_write),
    .wb_rd(wb_rd), .wb_reg_write(wb_reg_write),
    .mc_start(mc_start), .mc_done(mc_done),
    .branch_taken(branch_taken),
    .stall_IF(obsA[11]), .stall_DEC(obsA[10]),
    .stall_EX(obsA[9]), .kill_DEC(obsA[8]),
    .flush_IF(obsA[7]), .flush_DEC(obsA[6]),
    .mc_err(obsA[5]), .busy(obsA[4]),
    .fwd_a(obsA[3:2]), .fwd_b(obsA[1:0])
  );

  hazard_ctrl #(.REG_AW(5), .LOAD_STALL(3), .MC_TIMEOUT(16)) dutB (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .mem_rd(mem_rd), .mem_reg_write(mem_reg_write),
    .wb_rd(wb_rd), .wb_reg_write(wb_reg_write),
    .mc_start(mc_start), .mc_done(mc_done),
    .branch_taken(branch_taken),
    .stall_IF(obsB[11]), .stall_DEC(obsB[10]),
    .stall_EX(obsB[9]), .kill_DEC(obsB[8]),
    .flush_IF(obsB[7]), .flush_DEC(obsB[6]),
    .mc_err(obsB[5]), .busy(obsB[4]),
    .fwd_a(obsB[3:2]), .fwd_b(obsB[1:0])
  );

  always #5 clk = ~clk;

  function automatic bit luHit();
    return ex_mem_read && ex_reg_write && ex_rd != 0
        && ((id_use_rs1 && id_rs1 == ex_rd)
         || (id_use_rs2 && id_rs2 == ex_rd));
  endfunction

  function automatic logic [1:0] fwdRef(logic [4:0] rs);
    if (mem_reg_write && mem_rd != 0 && mem_rd == rs) return 2'b01;
    if (wb_reg_write && wb_rd != 0 && wb_rd == rs) return 2'b10;
    return 2'b00;
  endfunction

  // model: pending extra bubbles, or age of an outstanding mc op
  function automatic logic [11:0] expOut(int mt, int bub,
                                         bit inMc, int age);
    logic [11:0] e;
    e = '0;
    if (rst) return e;
    if (inMc) begin
      e[4] = 1'b1;
      if (!mc_done) begin
        if (age == mt - 1) e[5] = 1'b1;
        else e[11:9] = 3'b111;
      end
    end else if (branch_taken) begin
      e[7:6] = 2'b11;
    end else if (bub > 0) begin
      e = e | S_LU;
    end else if (!mc_start && luHit()) begin
      e = e | S_LU;
    end
    if (!inMc && bub > 0) e[4] = 1'b1;
    e[3:2] = fwdRef(ex_rs1);
    e[1:0] = fwdRef(ex_rs2);
    return e;
  endfunction

  task automatic modelStep(input int ls, input int mt, inout int bub,
                           inout bit inMc, inout int age);
    if (rst) begin
      bub = 0; inMc = 1'b0; age = 0;
    end else if (inMc) begin
      if (mc_done || age == mt - 1) begin
        inMc = 1'b0; age = 0;
      end else begin
        age = age + 1;
      end
    end else if (bub > 0) begin
      if (branch_taken) bub = 0;
      else bub = bub - 1;
    end else if (!branch_taken) begin
      if (mc_start) begin
        inMc = 1'b1; age = 0;
      end else if (luHit()) begin
        bub = ls - 1;
      end
    end
  endtask

  always @(posedge clk) begin
    modelStep(1, 8, bubA, mcA, ageA);
    modelStep(3, 16, bubB, mcB, ageB);
  end

  task automatic idle();
    id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
    ex_rs1 = 0; ex_rs2 = 0; ex_rd = 0;
    ex_reg_write = 0; ex_mem_read = 0;
    mem_rd = 0; mem_reg_write = 0; wb_rd = 0; wb_reg_write = 0;
    mc_start = 0; mc_done = 0; branch_taken = 0;
  endtask

  task automatic loadUse5();
    ex_mem_read = 1; ex_reg_write = 1; ex_rd = 5;
    id_rs1 = 5; id_use_rs1 = 1;
  endtask

  task automatic test_reset();
    rst = 1; idle(); loadUse5();
    mem_reg_write = 1; mem_rd = 3; ex_rs1 = 3; mc_start = 1;
    #1;
    checks++;
    if (obsA !== 12'h000) begin
      errors++; $display("FAIL reset_hold A: got %b exp %b", obsA, 12'h000);
    end
    checks++;
    if (obsB !== 12'h000) begin
      errors++; $display("FAIL reset_hold B: got %b exp %b", obsB, 12'h000);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 0; idle();
    #1;
    checks++;
    if (obsA !== 12'h000) begin
      errors++; $display("FAIL reset_rel A: got %b exp %b", obsA, 12'h000);
    end
    checks++;
    if (obsB !== 12'h000) begin
      errors++; $display("FAIL reset_rel B: got %b exp %b", obsB, 12'h000);
    end
    @(negedge clk);
  endtask

  task automatic test_load_use();
    logic [11:0] eA, eB;
    loadUse5();
    for (int k = 0; k < 4; k++) begin
      #1;
      eA = (k == 0) ? S_LU : 12'h000;
      eB = (k == 0) ? S_LU : (k < 3) ? (S_LU | BUSY) : 12'h000;
      checks++;
      if (obsA !== eA) begin
        errors++; $display("FAIL load_use A c%0d: got %b exp %b", k, obsA, eA);
      end
      checks++;
      if (obsB !== eB) begin
        errors++; $display("FAIL load_use B c%0d: got %b exp %b", k, obsB, eB);
      end
      @(negedge clk);
      idle();
    end
  endtask

  task automatic test_x0_fwd();
    logic [11:0] e;
    for (int k = 0; k < 5; k++) begin
      idle();
      ex_mem_read = 1; ex_reg_write = 1; ex_rd = 0;
      id_rs1 = 0; id_use_rs1 = 1; id_rs2 = 0; id_use_rs2 = 1;
      mem_reg_write = 1; mem_rd = 7; wb_reg_write = 1; wb_rd = 7;
      ex_rs1 = 3; ex_rs2 = 7;
      e = 12'h001;
      if (k == 1) begin mem_rd = 4; e = 12'h002; end
      if (k == 2) begin mem_rd = 4; ex_rs1 = 7; e = 12'h00A; end
      if (k == 3) begin mem_reg_write = 0; ex_rs1 = 7; e = 12'h00A; end
      if (k == 4) begin
        mem_rd = 0; wb_rd = 0; ex_rs1 = 0; ex_rs2 = 0; e = 12'h000;
      end
      #1;
      checks++;
      if (obsA !== e) begin
        errors++; $display("FAIL x0_fwd A c%0d: got %b exp %b", k, obsA, e);
      end
      checks++;
      if (obsB !== e) begin
        errors++; $display("FAIL x0_fwd B c%0d: got %b exp %b", k, obsB, e);
      end
      @(negedge clk);
    end
    idle();
  endtask

  task automatic test_mc_done();
    logic [11:0] e;
    mc_start = 1;
    for (int k = 0; k < 7; k++) begin
      #1;
      e = (k == 0 || k == 6) ? 12'h000 : (k < 5) ? (S_MC | BUSY) : BUSY;
      checks++;
      if (obsA !== e) begin
        errors++; $display("FAIL mc_done A c%0d: got %b exp %b", k, obsA, e);
      end
      checks++;
      if (obsB !== e) begin
        errors++; $display("FAIL mc_done B c%0d: got %b exp %b", k, obsB, e);
      end
      @(negedge clk);
      idle();
      if (k == 4) mc_done = 1;
    end
  endtask

  task automatic test_mc_timeout();
    logic [11:0] eA, eB;
    mc_start = 1;
    #1;
    @(negedge clk);
    idle();
    for (int k = 1; k <= 17; k++) begin
      #1;
      eA = (k < 8) ? (S_MC | BUSY) : (k == 8) ? (ERR | BUSY) : 12'h000;
      eB = (k < 16) ? (S_MC | BUSY) : (k == 16) ? (ERR | BUSY) : 12'h000;
      checks++;
      if (obsA !== eA) begin
        errors++; $display("FAIL mc_tmo A c%0d: got %b exp %b", k, obsA, eA);
      end
      checks++;
      if (obsB !== eB) begin
        errors++; $display("FAIL mc_tmo B c%0d: got %b exp %b", k, obsB, eB);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_branch_ldstall();
    logic [11:0] eA, eB;
    loadUse5();
    for (int k = 0; k < 3; k++) begin
      #1;
      eA = (k == 0) ? S_LU : (k == 1) ? FLUSH : 12'h000;
      eB = (k == 0) ? S_LU : (k == 1) ? (FLUSH | BUSY) : 12'h000;
      checks++;
      if (obsA !== eA) begin
        errors++; $display("FAIL br_ld A c%0d: got %b exp %b", k, obsA, eA);
      end
      checks++;
      if (obsB !== eB) begin
        errors++; $display("FAIL br_ld B c%0d: got %b exp %b", k, obsB, eB);
      end
      @(negedge clk);
      idle();
      if (k == 0) begin
        @(negedge clk);
        branch_taken = 1;
      end
    end
  endtask

  task automatic test_rst_mcwait();
    logic [11:0] e;
    mc_start = 1;
    for (int k = 0; k < 4; k++) begin
      #1;
      e = (k == 1) ? (S_MC | BUSY) : 12'h000;
      checks++;
      if (obsA !== e) begin
        errors++; $display("FAIL rst_mc A c%0d: got %b exp %b", k, obsA, e);
      end
      checks++;
      if (obsB !== e) begin
        errors++; $display("FAIL rst_mc B c%0d: got %b exp %b", k, obsB, e);
      end
      @(negedge clk);
      idle();
      rst = (k == 1);
      if (k == 1) begin
        loadUse5(); mem_reg_write = 1; mem_rd = 2; ex_rs2 = 2;
      end
    end
  endtask

  task automatic test_random();
    logic [11:0] eA, eB;
    for (int n = 0; n < 600; n++) begin
      rst = ($urandom_range(0, 59) == 0);
      id_rs1 = 5'($urandom_range(0, 3));
      id_rs2 = 5'($urandom_range(0, 3));
      ex_rs1 = 5'($urandom_range(0, 3));
      ex_rs2 = 5'($urandom_range(0, 3));
      ex_rd = 5'($urandom_range(0, 3));
      mem_rd = 5'($urandom_range(0, 3));
      wb_rd = 5'($urandom_range(0, 3));
      id_use_rs1 = 1'($urandom);
      id_use_rs2 = 1'($urandom);
      ex_reg_write = 1'($urandom);
      ex_mem_read = 1'($urandom);
      mem_reg_write = 1'($urandom);
      wb_reg_write = 1'($urandom);
      mc_start = ($urandom_range(0, 7) == 0);
      mc_done = ($urandom_range(0, 5) == 0);
      branch_taken = ($urandom_range(0, 9) == 0);
      #1;
      eA = expOut(8, bubA, mcA, ageA);
      eB = expOut(16, bubB, mcB, ageB);
      checks++;
      if (obsA !== eA) begin
        errors++; $display("FAIL rand A n%0d: got %b exp %b", n, obsA, eA);
      end
      checks++;
      if (obsB !== eB) begin
        errors++; $display("FAIL rand B n%0d: got %b exp %b", n, obsB, eB);
      end
      @(negedge clk);
    end
    rst = 0;
    idle();
  endtask

  initial begin
    rst = 1;
    idle();
    @(negedge clk);
    test_reset();
    test_load_use();
    test_x0_fwd();
    test_mc_done();
    test_mc_timeout();
    test_branch_ldstall();
    test_rst_mcwait();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
